// File: rtl/control_tiempo.sv
// control_tiempo: seconds/minutes/hours timekeeping with a small edit-mode FSM,
// plus a round-robin scheduler that shares one registered binary-to-BCD decoder
// across the three fields and captures each result into its own BCD register.
module control_tiempo #(
    parameter int HORAS_MAX = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_modo,
    input  logic       btn_subir,
    input  logic       btn_bajar,
    output logic [5:0] cuenta,
    input  logic [7:0] deco_salida,
    output logic [7:0] bcd_seg,
    output logic [7:0] bcd_min,
    output logic [7:0] bcd_hora,
    output logic [1:0] modo,
    output logic       bcd_valido
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] SET_HORA = 2'd1;
    localparam logic [1:0] SET_MIN  = 2'd2;
    localparam logic [1:0] SET_SEG  = 2'd3;

    localparam logic [5:0] SEXA_TOP = 6'd59;
    localparam logic [5:0] HORA_TOP = 6'(HORAS_MAX - 1);

    logic [5:0] r_seg, r_min, r_hora;
    logic [1:0] r_modo;
    logic [5:0] w_seg_next, w_min_next, w_hora_next;
    logic [1:0] w_modo_next;
    logic       w_up, w_dn;

    // Scheduler state: slot counter and the two-stage tag/valid delay line
    // that lines each decoder result up with the field it belongs to.
    logic [1:0] r_fase;
    logic [5:0] r_cuenta;
    logic       r_t1_vld, r_t2_vld;
    logic [1:0] r_t1_tag, r_t2_tag;
    logic       r_bcd_valido;
    logic [7:0] w_bcd [3];

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] top);
        return (v >= top) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec_wrap(input logic [5:0] v, input logic [5:0] top);
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    // Next-state for the mode FSM and the three time counters.
    always_comb begin
        w_seg_next  = r_seg;
        w_min_next  = r_min;
        w_hora_next = r_hora;
        w_modo_next = r_modo;
        // Pressing both edit buttons together cancels out.
        w_up = btn_subir & ~btn_bajar;
        w_dn = btn_bajar & ~btn_subir;

        if (btn_modo) begin
            w_modo_next = r_modo + 2'd1;
        end

        if (r_modo == RUN) begin
            // The tick still applies when btn_modo arrives in the same cycle.
            if (tick_1hz) begin
                w_seg_next = inc_wrap(r_seg, SEXA_TOP);
                if (r_seg == SEXA_TOP) begin
                    w_min_next = inc_wrap(r_min, SEXA_TOP);
                    if (r_min == SEXA_TOP) begin
                        w_hora_next = inc_wrap(r_hora, HORA_TOP);
                    end
                end
            end
        end else if (!btn_modo) begin
            // Edit only the selected field, no carry/borrow; time is frozen.
            case (r_modo)
                SET_HORA: begin
                    if (w_up) w_hora_next = inc_wrap(r_hora, HORA_TOP);
                    if (w_dn) w_hora_next = dec_wrap(r_hora, HORA_TOP);
                end
                SET_MIN: begin
                    if (w_up) w_min_next = inc_wrap(r_min, SEXA_TOP);
                    if (w_dn) w_min_next = dec_wrap(r_min, SEXA_TOP);
                end
                SET_SEG: begin
                    if (w_up) w_seg_next = inc_wrap(r_seg, SEXA_TOP);
                    if (w_dn) w_seg_next = dec_wrap(r_seg, SEXA_TOP);
                end
                default: ;
            endcase
        end
    end

    // Register the counters and the mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg  <= 6'd0;
            r_min  <= 6'd0;
            r_hora <= 6'd0;
            r_modo <= RUN;
        end else begin
            r_seg  <= w_seg_next;
            r_min  <= w_min_next;
            r_hora <= w_hora_next;
            r_modo <= w_modo_next;
        end
    end

    // Round-robin feed of the shared decoder and tag/valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fase       <= 2'd0;
            r_cuenta     <= 6'd0;
            r_t1_vld     <= 1'b0;
            r_t2_vld     <= 1'b0;
            r_t1_tag     <= 2'd0;
            r_t2_tag     <= 2'd0;
            r_bcd_valido <= 1'b0;
        end else begin
            r_fase <= (r_fase == 2'd2) ? 2'd0 : r_fase + 2'd1;
            case (r_fase)
                2'd0:    r_cuenta <= r_seg;
                2'd1:    r_cuenta <= r_min;
                default: r_cuenta <= r_hora;
            endcase
            r_t1_vld     <= 1'b1;
            r_t1_tag     <= r_fase;
            r_t2_vld     <= r_t1_vld;
            r_t2_tag     <= r_t1_tag;
            r_bcd_valido <= r_t2_vld && (r_t2_tag == 2'd2);
        end
    end

    // One capture register per field; slot gi owns field gi (seg, min, hora).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cap
            logic [7:0] r_cap;
            // Capture the decoder output when the delayed tag names this field.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cap <= 8'h00;
                end else if (r_t2_vld && (r_t2_tag == 2'(gi))) begin
                    r_cap <= deco_salida;
                end
            end
            assign w_bcd[gi] = r_cap;
        end
    endgenerate

    assign cuenta     = r_cuenta;
    assign bcd_seg    = w_bcd[0];
    assign bcd_min    = w_bcd[1];
    assign bcd_hora   = w_bcd[2];
    assign modo       = r_modo;
    assign bcd_valido = r_bcd_valido;

endmodule
